// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Single-port memory arbiter between the instruction-fetch and data-memory
//   requesters of the pipelined core. It runs one RAM transaction at a time
//   and produces the ihit/dhit strobes that let the hazard unit advance or
//   stall the pipeline.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request / word address
//   iload, ihit          instruction read data / completion pulse
//   dREN, dWEN           data read / write request
//   daddr, dstore        data word address / write value
//   dload, dhit          data read data / completion pulse
//   ramREN, ramWEN       RAM read / write enables
//   ramaddr, ramstore    RAM address / write data
//   ramload              RAM read data, valid with ram_rdy
//   ram_rdy, ram_err     RAM access complete / RAM fault
//   bus_err              sticky error flag, cleared only by reset
//
// Optional build macro
//   ARB_STARVE_GUARD_EN  after STARVE_LIMIT back-to-back data grants taken
//                        while iREN was waiting, the next grant goes to the
//                        instruction side. Undefined: strict data priority.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy,
  input  logic        ram_err,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    ERROR
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic data_req;
  logic grant_i;
  logic grant_d;
  logic timeout_hit;
  logic access_ok;

  // The low address bits are forced to zero (word addressing), so they are
  // deliberately not consumed.
  logic unused_bits;

  assign data_req    = dREN | dWEN;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  // ram_err overrides a simultaneous ram_rdy.
  assign access_ok   = ram_rdy & ~ram_err;

`ifdef ARB_STARVE_GUARD_EN
  localparam int S_W = $clog2(STARVE_LIMIT + 1);

  logic [S_W-1:0] starve_cnt_reg;
  logic           starve_force;

  assign starve_force = iREN & (starve_cnt_reg >= S_W'(STARVE_LIMIT));
  assign grant_i      = iREN & (~data_req | starve_force);
  assign unused_bits  = ^{iaddr[1:0], daddr[1:0]};
`else
  assign grant_i      = iREN & ~data_req;
  assign unused_bits  = ^{iaddr[1:0], daddr[1:0], 1'(STARVE_LIMIT != 0)};
`endif

  assign grant_d = data_req & ~grant_i;

  // Hits are combinational on ram_rdy so the pipeline can advance in the
  // same cycle the RAM completes; read data is only exposed during a hit.
  assign ihit  = (state_reg == IACC) & access_ok;
  assign dhit  = (state_reg == DACC) & access_ok;
  assign iload = ihit ? ramload : 32'h0;
  assign dload = dhit ? ramload : 32'h0;

  // The RAM-side output registers double as the grant latch: once loaded in
  // IDLE they hold the transaction regardless of later requester changes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      ramREN         <= 1'b0;
      ramWEN         <= 1'b0;
      ramaddr        <= 32'h0;
      ramstore       <= 32'h0;
      bus_err        <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (grant_i) begin
            state_reg <= IACC;
            ramREN    <= 1'b1;
            ramWEN    <= 1'b0;
            ramaddr   <= {iaddr[31:2], 2'b00};
            ramstore  <= 32'h0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_reg <= '0;
`endif
          end else if (grant_d) begin
            state_reg <= DACC;
            // A write wins when both dREN and dWEN are raised.
            ramREN    <= ~dWEN;
            ramWEN    <= dWEN;
            ramaddr   <= {daddr[31:2], 2'b00};
            ramstore  <= dstore;
`ifdef ARB_STARVE_GUARD_EN
            if (iREN) starve_cnt_reg <= starve_cnt_reg + S_W'(1);
            else      starve_cnt_reg <= '0;
`endif
          end
        end

        DACC, IACC: begin
          if (ram_err || (!ram_rdy && timeout_hit)) begin
            state_reg <= ERROR;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= 32'h0;
            ramstore  <= 32'h0;
            bus_err   <= 1'b1;
            cnt_reg   <= '0;
          end else if (ram_rdy) begin
            state_reg <= IDLE;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= 32'h0;
            ramstore  <= 32'h0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
          end
        end

        ERROR: begin
          // Terminal until reset.
          bus_err <= 1'b1;
          ramREN  <= 1'b0;
          ramWEN  <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_rdy, ram_err;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.TIMEOUT(64), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_rdy(ram_rdy), .ram_err(ram_err), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".ramREN"},   32'(ramREN),   32'h0);
    chk({tag, ".ramWEN"},   32'(ramWEN),   32'h0);
    chk({tag, ".ramaddr"},  ramaddr,       32'h0);
    chk({tag, ".ramstore"}, ramstore,      32'h0);
    chk({tag, ".ihit"},     32'(ihit),     32'h0);
    chk({tag, ".dhit"},     32'(dhit),     32'h0);
    chk({tag, ".iload"},    iload,         32'h0);
    chk({tag, ".dload"},    dload,         32'h0);
  endtask

  initial begin
    logic exp_i;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_rdy = 0; ram_err = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    // ---- reset state
    #2;
    chk_idle_outputs("reset");
    chk("reset.bus_err", 32'(bus_err), 32'h0);
    step();
    nRST = 1'b1;
    step();

    // ---- instruction read, ram_rdy one cycle after enable
    iREN = 1; iaddr = 32'h40; #1;                    // cycle 0 (IDLE)
    chk("ifetch.c0.ramREN", 32'(ramREN), 32'h0);
    step();                                          // cycle 1 (IACC)
    iaddr = 32'h999;                                 // must not disturb the latch
    #1;
    chk("ifetch.c1.ramREN", 32'(ramREN), 32'h1);
    chk("ifetch.c1.ramaddr", ramaddr, 32'h40);
    chk("ifetch.c1.ihit", 32'(ihit), 32'h0);
    step();                                          // cycle 2
    ram_rdy = 1; ramload = 32'h8C220004; #1;
    chk("ifetch.c2.ramaddr", ramaddr, 32'h40);
    chk("ifetch.c2.ihit", 32'(ihit), 32'h1);
    chk("ifetch.c2.iload", iload, 32'h8C220004);
    chk("ifetch.c2.dhit", 32'(dhit), 32'h0);
    step();
    iREN = 0; ram_rdy = 0; #1;
    chk_idle_outputs("ifetch.c3");

    // ---- simultaneous iREN + dWEN: data first, then instruction
    iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h103; dstore = 32'hDEADBEEF;
    step();                                          // DACC
    chk("both.d.ramWEN", 32'(ramWEN), 32'h1);
    chk("both.d.ramREN", 32'(ramREN), 32'h0);
    chk("both.d.ramaddr", ramaddr, 32'h100);
    chk("both.d.ramstore", ramstore, 32'hDEADBEEF);
    ram_rdy = 1; #1;
    chk("both.d.dhit", 32'(dhit), 32'h1);
    chk("both.d.ihit", 32'(ihit), 32'h0);
    step();                                          // IDLE gap
    dWEN = 0; ram_rdy = 0; #1;
    chk("both.gap.ramWEN", 32'(ramWEN), 32'h0);
    chk("both.gap.ramREN", 32'(ramREN), 32'h0);
    chk("both.gap.dhit", 32'(dhit), 32'h0);
    step();                                          // IACC
    chk("both.i.ramREN", 32'(ramREN), 32'h1);
    chk("both.i.ramaddr", ramaddr, 32'h80);
    ram_rdy = 1; ramload = 32'h00001234; #1;
    chk("both.i.ihit", 32'(ihit), 32'h1);
    chk("both.i.iload", iload, 32'h00001234);
    chk("both.i.dhit", 32'(dhit), 32'h0);
    step();
    iREN = 0; ram_rdy = 0;

    // ---- timeout: dREN held, no ram_rdy
    dREN = 1; daddr = 32'h200;
    step();                                          // access cycle 1, counter 0
    for (int k = 0; k < 63; k++) step();             // access cycle 64, counter 63
    chk("tmo.c64.ramREN", 32'(ramREN), 32'h1);
    chk("tmo.c64.bus_err", 32'(bus_err), 32'h0);
    chk("tmo.c64.dhit", 32'(dhit), 32'h0);
    step();                                          // ERROR
    chk("tmo.err.bus_err", 32'(bus_err), 32'h1);
    chk("tmo.err.ramREN", 32'(ramREN), 32'h0);
    ram_rdy = 1; iREN = 1; #1;
    chk("tmo.err.dhit", 32'(dhit), 32'h0);
    step();
    step();
    chk("tmo.sticky.bus_err", 32'(bus_err), 32'h1);
    chk("tmo.sticky.ramREN", 32'(ramREN), 32'h0);
    chk("tmo.sticky.ihit", 32'(ihit), 32'h0);
    nRST = 0; dREN = 0; iREN = 0; ram_rdy = 0; #1;
    chk("tmo.rst.bus_err", 32'(bus_err), 32'h0);
    step();
    nRST = 1;
    step();

    // ---- ram_rdy and ram_err together during IACC
    iREN = 1; iaddr = 32'h44;
    step();
    ram_rdy = 1; ram_err = 1; #1;
    chk("rdyerr.ihit", 32'(ihit), 32'h0);
    step();
    chk("rdyerr.bus_err", 32'(bus_err), 32'h1);
    chk("rdyerr.ramREN", 32'(ramREN), 32'h0);
    chk("rdyerr.ihit2", 32'(ihit), 32'h0);
    nRST = 0; iREN = 0; ram_rdy = 0; ram_err = 0;
    step();
    nRST = 1;
    step();

    // ---- reset mid-DACC, then a fresh read completes
    dREN = 1; daddr = 32'h300;
    step();
    chk("midrst.ramREN", 32'(ramREN), 32'h1);
    chk("midrst.ramaddr", ramaddr, 32'h300);
    nRST = 0; ram_rdy = 1; #1;
    chk_idle_outputs("midrst.async");
    step();
    ram_rdy = 0; nRST = 1;                           // IDLE with dREN still high
    step();
    chk("fresh.ramREN", 32'(ramREN), 32'h1);
    chk("fresh.ramaddr", ramaddr, 32'h300);
    ram_rdy = 1; ramload = 32'hCAFEF00D; #1;
    chk("fresh.dhit", 32'(dhit), 32'h1);
    chk("fresh.dload", dload, 32'hCAFEF00D);
    step();

    // ---- dREN and iREN held continuously, ram_rdy always high
    dREN = 1; iREN = 1; ram_rdy = 1; daddr = 32'h500; iaddr = 32'h600;
    for (int k = 0; k < 10; k++) begin
      step();                                        // access cycle
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (k % 5 == 4);
`else
      exp_i = 1'b0;
`endif
      chk($sformatf("starve.%0d.ihit", k), 32'(ihit), 32'(exp_i));
      chk($sformatf("starve.%0d.dhit", k), 32'(dhit), 32'(!exp_i));
      chk($sformatf("starve.%0d.ramaddr", k), ramaddr, exp_i ? 32'h600 : 32'h500);
      step();                                        // IDLE
    end
    dREN = 0; iREN = 0; ram_rdy = 0;
    step();
    chk_idle_outputs("end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction-fetch and data-memory requesters of the pipelined core.
- Sequences one RAM transaction at a time.
- Generates the ihit/dhit strobes that the hazard unit uses to advance or stall the pipeline.
- Sits between the cache/datapath request side and the unified RAM port.

Parameters:
TIMEOUT, 64, cycles to wait for ram_rdy before declaring a bus error (>=2)
STARVE_LIMIT, 4, consecutive data grants allowed while iREN pending (used only with ARB_STARVE_GUARD_EN)

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request, held until ihit
iaddr  in  32  instruction word address
iload  out  32  instruction read data, valid when ihit
ihit  out  1  instruction transaction complete (one-cycle pulse)
dREN  in  1  data read request, held until dhit
dWEN  in  1  data write request, held until dhit
daddr  in  32  data word address
dstore  in  32  data write value
dload  out  32  data read data, valid when dhit
dhit  out  1  data transaction complete (one-cycle pulse)
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid when ram_rdy
ram_rdy  in  1  RAM access complete this cycle
ram_err  in  1  RAM signals fault this cycle
bus_err  out  1  sticky error flag

Behaviour:
- Reset (async, nRST low): state=IDLE, timeout counter=0, grant latch cleared; ramREN=ramWEN=0, ramaddr=ramstore=0, ihit=dhit=0, bus_err=0. iload/dload read as 0 outside a hit cycle.
- States: IDLE, DACC, IACC, ERROR.
- IDLE:
  - dREN|dWEN -> DACC (data priority).
  - Else iREN -> IACC.
  - Else stay.
  - On grant, latch address (bits [1:0] forced to 00), store data and op into registers.
  - No RAM enables asserted in IDLE.
- DACC/IACC:
  - Drive ramaddr/ramstore from the latch.
  - ramWEN=1 if latched op is a write, else ramREN=1. dWEN wins if dREN&dWEN.
  - IACC is always a read.
  - Counter increments each cycle in the state.
  - ram_rdy=1 -> the owning hit=1 combinationally that cycle. Read data passes through from ramload to iload/dload. Next state IDLE; counter cleared.
  - ram_err=1, or counter reaches TIMEOUT-1 without ram_rdy -> ERROR. No hit is issued.
  - ram_rdy and ram_err in the same cycle: ram_err wins.
- ERROR: bus_err=1, all RAM enables 0, no hits. Exits only via reset.
- Latency: request visible in IDLE at cycle 0; RAM enables asserted at cycle 1; earliest hit at cycle 1. Minimum 2 cycles per access, with at least one IDLE cycle between transactions.
- Requests are sampled only in IDLE. A request that drops mid-transaction does not abort it: the transaction completes and the hit still pulses.
- Latched address/data are immune to input changes after grant.
- ihit and dhit are never asserted in the same cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. No hit is issued.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined: a counter tracks consecutive data grants issued while iREN was high in the granting IDLE cycle. When it reaches STARVE_LIMIT, the next IDLE grant goes to iREN even if a data request is pending.
- The counter clears on any instruction grant, or on a data grant with iREN low.
- Undefined: strict data priority, no counter.

Test Plan:
- Reset with all requests low -> all outputs 0, state IDLE; assert iREN iaddr=0x40, ram_rdy 1 cycle after enable, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40, ihit pulse with iload=0x8C220004 two cycles after request.
- iREN and dWEN together, daddr=0x103 dstore=0xDEADBEEF -> ramWEN with ramaddr=0x100 first, dhit; one IDLE cycle; then ramREN for the instruction, ihit.
- dREN held, ram_rdy withheld -> bus_err=1 after TIMEOUT=64 cycles; ramREN=0; no dhit; stays until nRST.
- ram_rdy and ram_err in the same cycle during IACC -> ERROR, ihit stays 0.
- nRST pulsed low mid-DACC -> outputs reset asynchronously, no dhit; after release, a fresh dREN completes normally.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dREN and iREN held continuously -> four dhits, then one ihit, repeating. Without the macro -> only dhits.
